// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 UART receiver: 2-flop synchronizer, mid-bit majority vote,
// and a single-entry holding register presented on a valid/ready output.
module uart_rx_sampler #(
    parameter int ClkFrequency = 80_000_000,
    parameter int Baud         = 115200,
    parameter int Oversample   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       idle
);

    localparam int TICK_DIV_RAW = ClkFrequency / (Baud * Oversample);
    localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int TICK_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SAMP_W       = $clog2(Oversample);
    localparam int MID          = Oversample / 2;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST  = SAMP_W'(Oversample - 1);
    localparam logic [SAMP_W-1:0] SAMP_VOTE0 = SAMP_W'(MID - 1);
    localparam logic [SAMP_W-1:0] SAMP_VOTE1 = SAMP_W'(MID);
    localparam logic [SAMP_W-1:0] SAMP_VOTE2 = SAMP_W'(MID + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t              state, state_n;
    logic                rxd_meta, rxd_s;
    logic [TICK_W-1:0]   tick_cnt;
    logic [SAMP_W-1:0]   samp_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic                vote_a, vote_b;
    logic                bit_sampled;

    logic counting, tick, vote_now, bit_end, majority;
    logic clear_cnt, shift_en, bit_inc, bit_clr, sampled_set, sampled_clr;
    logic byte_done, fe_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    assign counting = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign tick     = counting && (tick_cnt == TICK_LAST);
    assign vote_now = tick && (samp_cnt == SAMP_VOTE2);
    assign bit_end  = tick && (samp_cnt == SAMP_LAST);
    assign majority = (vote_a & vote_b) | (vote_a & rxd_s) | (vote_b & rxd_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        clear_cnt   = 1'b0;
        shift_en    = 1'b0;
        bit_inc     = 1'b0;
        bit_clr     = 1'b0;
        sampled_set = 1'b0;
        sampled_clr = 1'b0;
        byte_done   = 1'b0;
        fe_set      = 1'b0;
        case (state)
            ST_IDLE: begin
                clear_cnt = 1'b1;
                if (!rxd_s) state_n = ST_START;
            end
            ST_START: begin
                if (vote_now) begin
                    if (majority) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n     = ST_DATA;
                        bit_clr     = 1'b1;
                        sampled_clr = 1'b1;
                    end
                end
            end
            // The tail of the start bit is still running on entry, so a bit only
            // closes at the sample wrap once its own vote has been taken.
            ST_DATA: begin
                if (vote_now) begin
                    shift_en    = 1'b1;
                    sampled_set = 1'b1;
                end
                if (bit_end) begin
                    sampled_clr = 1'b1;
                    if (bit_sampled) begin
                        if (bit_idx == 3'd7) state_n = ST_STOP;
                        else                 bit_inc = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (vote_now) begin
                    if (majority) begin
                        byte_done = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_n = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                clear_cnt = 1'b1;
                if (rxd_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else if (clear_cnt) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else if (counting) begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            if (tick) samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SAMP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_a      <= 1'b0;
            vote_b      <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            bit_sampled <= 1'b0;
        end else begin
            if (tick && samp_cnt == SAMP_VOTE0) vote_a <= rxd_s;
            if (tick && samp_cnt == SAMP_VOTE1) vote_b <= rxd_s;
            if (shift_en) shreg <= {majority, shreg[7:1]};
            if (bit_clr)      bit_idx <= '0;
            else if (bit_inc) bit_idx <= bit_idx + 3'd1;
            if (sampled_clr)      bit_sampled <= 1'b0;
            else if (sampled_set) bit_sampled <= 1'b1;
        end
    end

    // Output handshake: a byte transfers on any posedge with out_valid=1 and
    // out_ready=1; out_valid never drops and out_data never changes until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= fe_set;
            overrun     <= byte_done && out_valid && !out_ready;
            if (byte_done && (!out_valid || out_ready)) begin
                out_data  <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign idle = (state == ST_IDLE) && rxd_s;

endmodule
